// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: opcode/funct constants,
// ALU op codes (also used by the ALU), FSM state encodings, and the decoded
// instruction class, plus small helpers that map a class to datapath controls.
package mc_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  // Next-PC select
  localparam logic [1:0] NPC_SEQ    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;

  // Register write-data select
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_LUI = 2'd2;

  // ALU operation codes, shared with the ALU
  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUBU = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SLL  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRA  = 4'd6
  } alu_op_e;

  // FSM states; codes 5-7 are illegal
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Decoded instruction class; CL_NOP covers every unsupported encoding
  typedef enum logic [3:0] {
    CL_NOP,
    CL_ADDU,
    CL_SUBU,
    CL_SLL,
    CL_SRL,
    CL_SRA,
    CL_ORI,
    CL_LUI,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J
  } iclass_e;

  // ALU operation required in EXEC for a given class
  function automatic alu_op_e alu_op_for(input iclass_e cls);
    case (cls)
      CL_ADDU, CL_LW, CL_SW: return ALU_ADDU;
      CL_SUBU, CL_BEQ:       return ALU_SUBU;
      CL_ORI:                return ALU_OR;
      CL_SLL:                return ALU_SLL;
      CL_SRL:                return ALU_SRL;
      CL_SRA:                return ALU_SRA;
      default:               return ALU_NONE;
    endcase
  endfunction

  // Classes whose ALU B operand is the (extended) immediate
  function automatic logic uses_imm(input iclass_e cls);
    return (cls == CL_ORI) || (cls == CL_LW) || (cls == CL_SW);
  endfunction

  // Classes that write rd rather than rt
  function automatic logic is_rtype(input iclass_e cls);
    return (cls == CL_ADDU) || (cls == CL_SUBU) || (cls == CL_SLL) ||
           (cls == CL_SRL)  || (cls == CL_SRA);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Purpose: classify the instruction register contents into an instruction class.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: instr (IR contents) in; iclass (decoded class, CL_NOP if unsupported) out.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_e     iclass
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_fields = ^instr[25:6];

  always_comb begin
    iclass = CL_NOP;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = CL_ADDU;
          FN_SUBU: iclass = CL_SUBU;
          FN_SLL:  iclass = CL_SLL;
          FN_SRL:  iclass = CL_SRL;
          FN_SRA:  iclass = CL_SRA;
          default: iclass = CL_NOP;
        endcase
      end
      OP_J:    iclass = CL_J;
      OP_BEQ:  iclass = CL_BEQ;
      OP_ORI:  iclass = CL_ORI;
      OP_LUI:  iclass = CL_LUI;
      OP_LW:   iclass = CL_LW;
      OP_SW:   iclass = CL_SW;
      default: iclass = CL_NOP;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Purpose: multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB), Moore outputs per class.
// Latency: 2 cycles (j, nop), 3 (beq), 4 (R-type, ori, lui, sw), 5 (lw).
// Backpressure: none; one state per clock, reset aborts the instruction at once.
// Ports: clk, reset (async, active-high), instr, alu_eq in; alu_ctrl, alu_src_b,
//        ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel, mem_we, state out.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_eq,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src_b,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  npc_sel,
  output logic        reg_we,
  output logic        reg_dst,
  output logic [1:0]  wd_sel,
  output logic        mem_we,
  output logic [2:0]  state
);

  state_e  state_q;
  state_e  state_d;
  iclass_e iclass;

  mc_decode u_decode (
    .instr  (instr),
    .iclass (iclass)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if ((iclass == CL_J) || (iclass == CL_NOP)) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (iclass)
          CL_LW, CL_SW: state_d = ST_MEM;
          CL_ADDU, CL_SUBU, CL_SLL, CL_SRL, CL_SRA, CL_ORI, CL_LUI:
            state_d = ST_WB;
          default: state_d = ST_FETCH;  // beq, or IR changed underneath us
        endcase
      end
      ST_MEM: state_d = (iclass == CL_LW) ? ST_WB : ST_FETCH;
      ST_WB:  state_d = ST_FETCH;
      default: state_d = ST_FETCH;      // illegal codes recover in one edge
    endcase
  end

  // Output logic. Reset gates everything directly: the register is already
  // forced to FETCH, but FETCH strobes must not fire until reset is released.
  always_comb begin
    alu_ctrl  = ALU_NONE;
    alu_src_b = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    npc_sel   = NPC_SEQ;
    reg_we    = 1'b0;
    reg_dst   = 1'b0;
    wd_sel    = WD_ALU;
    mem_we    = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          npc_sel = NPC_SEQ;
        end
        ST_DECODE: begin
          if (iclass == CL_J) begin
            pc_we   = 1'b1;
            npc_sel = NPC_JUMP;
          end
        end
        ST_EXEC: begin
          alu_ctrl  = alu_op_for(iclass);
          alu_src_b = uses_imm(iclass);
          if (iclass == CL_BEQ) begin
            pc_we   = alu_eq;
            npc_sel = NPC_BRANCH;
          end
        end
        ST_MEM: begin
          mem_we = (iclass == CL_SW);
        end
        ST_WB: begin
          reg_we  = 1'b1;
          reg_dst = is_rtype(iclass);
          if (iclass == CL_LW) begin
            wd_sel = WD_MEM;
          end else if (iclass == CL_LUI) begin
            wd_sel = WD_LUI;
          end else begin
            wd_sel = WD_ALU;
          end
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule
